// File: rtl/mem_port_arbiter_if.sv
// Request ports of fetch (0) and load/store (1) plus the memory-side steering/access bus.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic              req0;
   logic [AWIDTH-1:0] addr0;
   logic              req1;
   logic [AWIDTH-1:0] addr1;
   logic              we1;
   logic [DWIDTH-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              done0;
   logic              done1;
   logic [DWIDTH-1:0] rdata;
   logic              mem_sel;
   logic              mem_en;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdata;
   logic [DWIDTH-1:0] mem_rdata;

   modport slave (
      input  req0, addr0, req1, addr1, we1, wdata1, mem_rdata,
      output gnt0, gnt1, done0, done1, rdata, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req0, addr0, req1, addr1, we1, wdata1, mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-ported memory: alternating priority, fixed-latency
// access sequencing, registered outputs and a one-cycle done pulse to the winner.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       last_served;
   logic       pick1;

   // Port 1 wins when alone, or on contention when port 0 was served last.
   assign pick1 = bus.req1 & (~bus.req0 | ~last_served);

   // NOTE: all state and outputs use non-blocking assignments so every register
   // samples pre-edge values; the reset branch is synchronous and clears everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         last_served   <= 1'b1;
         bus.gnt0      <= 1'b0;
         bus.gnt1      <= 1'b0;
         bus.done0     <= 1'b0;
         bus.done1     <= 1'b0;
         bus.rdata     <= {DWIDTH{1'b0}};
         bus.mem_sel   <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {AWIDTH{1'b0}};
         bus.mem_wdata <= {DWIDTH{1'b0}};
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state       <= BUSY;
                  cnt         <= CNT_INIT;
                  last_served <= pick1;
                  bus.gnt0    <= ~pick1;
                  bus.gnt1    <= pick1;
                  bus.mem_sel <= pick1;
                  bus.mem_en  <= 1'b1;
                  if (pick1) begin
                     bus.mem_addr  <= bus.addr1;
                     bus.mem_wdata <= bus.wdata1;
                     bus.mem_we    <= bus.we1;
                  end else begin
                     bus.mem_addr  <= bus.addr0;
                     bus.mem_we    <= 1'b0;
                  end
               end
            end

            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Captured on stores as well; the requester ignores it then.
                  bus.rdata  <= bus.mem_rdata;
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
                  bus.done0  <= bus.gnt0;
                  bus.done1  <= bus.gnt1;
                  bus.gnt0   <= 1'b0;
                  bus.gnt1   <= 1'b0;
                  state      <= DONE;
               end
            end

            DONE: begin
               bus.done0 <= 1'b0;
               bus.done1 <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected completions,
// a negedge monitor pops them as done pulses appear. Instance A: latency 2, B: latency 1.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   typedef struct {
      logic        port;
      logic [31:0] data;
      bit          chk_data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   en_cnt_a = 0;
   int   en_cnt_b = 0;
   bit   prev_done_a = 1'b0;
   bit   prev_done_b = 1'b0;
   exp_t q_a[$];
   exp_t q_b[$];

   mem_port_arbiter_if #(.DWIDTH(32), .AWIDTH(32)) bus_a ();
   mem_port_arbiter_if #(.DWIDTH(32), .AWIDTH(32)) bus_b ();

   mem_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .MEM_LATENCY(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   mem_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .MEM_LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Memory returns data only in the last cycle of the fixed-latency window.
   function automatic logic [31:0] pat(input logic [31:0] a);
      pat = (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
   endfunction

   always @(posedge clk) en_cnt_a <= bus_a.mem_en ? en_cnt_a + 1 : 0;
   always @(posedge clk) en_cnt_b <= bus_b.mem_en ? en_cnt_b + 1 : 0;
   assign bus_a.mem_rdata = (bus_a.mem_en && en_cnt_a == 1) ? pat(bus_a.mem_addr) : 32'hBAD0_0000;
   assign bus_b.mem_rdata = (bus_b.mem_en && en_cnt_b == 0) ? pat(bus_b.mem_addr) : 32'hBAD0_0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic port, input logic [31:0] data, input bit chk, input int c);
      exp_t e;
      e.port = port; e.data = data; e.chk_data = chk; e.cyc = c;
      return e;
   endfunction

   // Monitor A: pops on every done pulse, checks invariants each cycle.
   always @(negedge clk) begin
      exp_t e;
      check("a_gnt_excl", bus_a.gnt0 & bus_a.gnt1, 0);
      check("a_we_needs_gnt1", bus_a.mem_we & ~bus_a.gnt1, 0);
      if (bus_a.done0 || bus_a.done1) begin
         check("a_done_excl", bus_a.done0 & bus_a.done1, 0);
         check("a_done_width", prev_done_a, 0);
         if (q_a.size() == 0) begin
            check("a_unexpected_done", 1, 0);
         end else begin
            e = q_a.pop_front();
            check("a_done_port", bus_a.done1, e.port);
            check("a_done_cycle", cyc, e.cyc);
            if (e.chk_data) check("a_rdata", bus_a.rdata, e.data);
         end
      end
      prev_done_a = bus_a.done0 | bus_a.done1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus_b.done0 || bus_b.done1) begin
         check("b_done_width", prev_done_b, 0);
         if (q_b.size() == 0) begin
            check("b_unexpected_done", 1, 0);
         end else begin
            e = q_b.pop_front();
            check("b_done_port", bus_b.done1, e.port);
            check("b_done_cycle", cyc, e.cyc);
            if (e.chk_data) check("b_rdata", bus_b.rdata, e.data);
         end
      end
      prev_done_b = bus_b.done0 | bus_b.done1;
   end

   task automatic check_zero_a(input string tag);
      check({tag, "_gnt0"}, bus_a.gnt0, 0);
      check({tag, "_gnt1"}, bus_a.gnt1, 0);
      check({tag, "_done0"}, bus_a.done0, 0);
      check({tag, "_done1"}, bus_a.done1, 0);
      check({tag, "_rdata"}, bus_a.rdata, 0);
      check({tag, "_mem_sel"}, bus_a.mem_sel, 0);
      check({tag, "_mem_en"}, bus_a.mem_en, 0);
      check({tag, "_mem_we"}, bus_a.mem_we, 0);
      check({tag, "_mem_addr"}, bus_a.mem_addr, 0);
      check({tag, "_mem_wdata"}, bus_a.mem_wdata, 0);
   endtask

   // Returns at the negedge inside the done cycle, or flags a timeout.
   task automatic wait_done_a(input logic port, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = port ? bus_a.done1 : bus_a.done0;
      end
      check("a_done_timeout", got, 1);
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      bus_a.req0 = 1'b1; bus_a.addr0 = 32'h10;
      bus_a.req1 = 1'b1; bus_a.addr1 = 32'h20;
      bus_a.we1 = 1'b0;  bus_a.wdata1 = 32'h0;
      bus_b.req0 = 1'b0; bus_b.addr0 = 32'h0;
      bus_b.req1 = 1'b0; bus_b.addr1 = 32'h0;
      bus_b.we1 = 1'b0;  bus_b.wdata1 = 32'h0;

      // Reset with both requesting, then port 0 must win first.
      repeat (2) @(negedge clk);
      check_zero_a("rst");
      check("b_rst_gnt0", bus_b.gnt0, 0);
      check("b_rst_mem_en", bus_b.mem_en, 0);
      rst_n = 1'b1;
      t = cyc;
      q_a.push_back(mk(1'b0, pat(32'h10), 1'b1, t + 3));
      q_a.push_back(mk(1'b1, pat(32'h20), 1'b1, t + 7));
      @(negedge clk);
      check("post_rst_gnt0", bus_a.gnt0, 1);
      check("post_rst_gnt1", bus_a.gnt1, 0);
      check("post_rst_sel", bus_a.mem_sel, 0);
      check("post_rst_addr", bus_a.mem_addr, 32'h10);
      wait_done_a(1'b0, 6);
      bus_a.req0 = 1'b0;
      wait_done_a(1'b1, 8);
      bus_a.req1 = 1'b0;
      @(negedge clk);

      // Single fetch, with addr0 disturbed during BUSY.
      bus_a.req0 = 1'b1; bus_a.addr0 = 32'h100;
      t = cyc;
      q_a.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b1, t + 3));
      @(negedge clk);
      check("fetch_gnt0", bus_a.gnt0, 1);
      check("fetch_en", bus_a.mem_en, 1);
      check("fetch_we", bus_a.mem_we, 0);
      check("fetch_addr", bus_a.mem_addr, 32'h100);
      bus_a.addr0 = 32'h999;
      @(negedge clk);
      check("fetch_addr_stable", bus_a.mem_addr, 32'h100);
      check("fetch_gnt0_held", bus_a.gnt0, 1);
      check("fetch_done_early", bus_a.done0, 0);
      @(negedge clk);
      check("fetch_done0", bus_a.done0, 1);
      check("fetch_gnt0_off", bus_a.gnt0, 0);
      check("fetch_en_off", bus_a.mem_en, 0);
      bus_a.req0 = 1'b0;
      @(negedge clk);

      // Store from port 1.
      bus_a.req1 = 1'b1; bus_a.we1 = 1'b1; bus_a.addr1 = 32'h40; bus_a.wdata1 = 32'h1234;
      t = cyc;
      q_a.push_back(mk(1'b1, 32'h0, 1'b0, t + 3));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("store_sel", bus_a.mem_sel, 1);
         check("store_we", bus_a.mem_we, 1);
         check("store_wdata", bus_a.mem_wdata, 32'h1234);
         check("store_addr", bus_a.mem_addr, 32'h40);
      end
      @(negedge clk);
      check("store_done1", bus_a.done1, 1);
      check("store_done0", bus_a.done0, 0);
      check("store_we_off", bus_a.mem_we, 0);
      bus_a.req1 = 1'b0; bus_a.we1 = 1'b0;
      @(negedge clk);
      check("store_sel_hold", bus_a.mem_sel, 1);

      // Continuous contention: grants 0,1,0,1 every 4 cycles.
      bus_a.req0 = 1'b1; bus_a.addr0 = 32'h200;
      bus_a.req1 = 1'b1; bus_a.addr1 = 32'h300;
      t = cyc;
      for (int k = 0; k < 4; k++)
         q_a.push_back(mk(k[0], k[0] ? pat(32'h300) : pat(32'h200), 1'b1, t + 3 + 4 * k));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("cont_gnt0", bus_a.gnt0, !k[0]);
         check("cont_gnt1", bus_a.gnt1, k[0]);
         wait_done_a(k[0], 5);
         if (k == 3) begin
            bus_a.req0 = 1'b0;
            bus_a.req1 = 1'b0;
         end
         @(negedge clk);
      end

      // Reset during BUSY: no done, priority returns to port 0.
      bus_a.req0 = 1'b1; bus_a.addr0 = 32'h500;
      @(negedge clk);
      check("abort_gnt0", bus_a.gnt0, 1);
      rst_n = 1'b0;
      bus_a.req0 = 1'b0;
      @(negedge clk);
      check_zero_a("abort");
      rst_n = 1'b1;
      bus_a.req0 = 1'b1; bus_a.addr0 = 32'h600;
      bus_a.req1 = 1'b1; bus_a.addr1 = 32'h700;
      t = cyc;
      q_a.push_back(mk(1'b0, pat(32'h600), 1'b1, t + 3));
      q_a.push_back(mk(1'b1, pat(32'h700), 1'b1, t + 7));
      @(negedge clk);
      check("abort_next_gnt0", bus_a.gnt0, 1);
      check("abort_next_sel", bus_a.mem_sel, 0);
      wait_done_a(1'b0, 6);
      bus_a.req0 = 1'b0;
      wait_done_a(1'b1, 8);
      bus_a.req1 = 1'b0;
      @(negedge clk);

      // Latency 1 instance: done two cycles after the sample.
      bus_b.req0 = 1'b1; bus_b.addr0 = 32'h100;
      t = cyc;
      q_b.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b1, t + 2));
      @(negedge clk);
      check("b_gnt0", bus_b.gnt0, 1);
      check("b_mem_en", bus_b.mem_en, 1);
      @(negedge clk);
      check("b_done0", bus_b.done0, 1);
      check("b_gnt0_off", bus_b.gnt0, 0);
      bus_b.req0 = 1'b0;
      repeat (2) @(negedge clk);

      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
